prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 115 +++++++++++
 tb/tb_prog_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - serial configuration loader with even-parity check for a connection-block tile
module prog_loader #(
    parameter int PROG_W = 69,
    parameter int CNT_W  = 7
) (
    input  logic              clb_clk,
    input  logic              clb_rst_n,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    input  logic              cfg_bit,
    output logic              cfg_ready,
    output logic [PROG_W-1:0] prog,
    output logic              prog_valid,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Counter value at which the incoming bit is the parity bit rather than data
    localparam logic [CNT_W-1:0] PARITY_POS = CNT_W'(PROG_W);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               parity, parity_nxt;
    logic [PROG_W-1:0]  shadow, shadow_nxt;
    logic [PROG_W-1:0]  prog_nxt;
    logic               prog_valid_nxt;
    logic               done_nxt;
    logic               err_nxt;

    // Handshake and status decode straight from the current state
    always_comb begin
        cfg_ready = (state == SHIFT);
        busy      = (state != IDLE);
    end

    // Next-state logic: frame assembly in the shadow register, commit only after the parity check
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        parity_nxt     = parity;
        shadow_nxt     = shadow;
        prog_nxt       = prog;
        prog_valid_nxt = prog_valid;
        done_nxt       = 1'b0;
        err_nxt        = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    state_nxt  = SHIFT;
                    cnt_nxt    = '0;
                    parity_nxt = 1'b0;
                end
            end
            SHIFT: begin
                if (cfg_start) begin
                    // Restart drops whatever bit is on the bus this cycle
                    cnt_nxt    = '0;
                    parity_nxt = 1'b0;
                end else if (cfg_valid) begin
                    parity_nxt = parity ^ cfg_bit;
                    if (cnt == PARITY_POS) begin
                        state_nxt = CHECK;
                    end else begin
                        shadow_nxt = {shadow[PROG_W-2:0], cfg_bit};
                        cnt_nxt    = cnt + 1'b1;
                    end
                end
            end
            CHECK: begin
                state_nxt = IDLE;
                if (!parity) begin
                    prog_nxt       = shadow;
                    prog_valid_nxt = 1'b1;
                    done_nxt       = 1'b1;
                end else begin
                    err_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State registers; reset wipes any frame in flight and the committed word
    always_ff @(posedge clb_clk or negedge clb_rst_n) begin
        if (!clb_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            parity     <= 1'b0;
            shadow     <= '0;
            prog       <= '0;
            prog_valid <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            parity     <= parity_nxt;
            shadow     <= shadow_nxt;
            prog       <= prog_nxt;
            prog_valid <= prog_valid_nxt;
            cfg_done   <= done_nxt;
            cfg_err    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

    localparam int PW = 69;

    // 0x1_5555_5555_AAAA_AAAA holds 33 ones, so its even-parity bit is 1
    localparam logic [PW-1:0] PAT   = 69'h1_5555_5555_AAAA_AAAA;
    localparam logic [PW-1:0] ONES  = {PW{1'b1}};
    localparam logic [PW-1:0] ONE_W = 69'h0_0000_0000_0000_0001;

    logic          clb_clk = 1'b0;
    logic          clb_rst_n;
    logic          cfg_start;
    logic          cfg_valid;
    logic          cfg_bit;
    logic          cfg_ready;
    logic [PW-1:0] prog;
    logic          prog_valid;
    logic          cfg_done;
    logic          cfg_err;
    logic          busy;

    int checks    = 0;
    int errors    = 0;
    int acc_cnt   = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int pulse_bad = 0;
    int dc;
    int ec;
    logic prev_done = 1'b0;
    logic prev_err  = 1'b0;

    prog_loader #(.PROG_W(PW), .CNT_W(7)) dut (
        .clb_clk    (clb_clk),
        .clb_rst_n  (clb_rst_n),
        .cfg_start  (cfg_start),
        .cfg_valid  (cfg_valid),
        .cfg_bit    (cfg_bit),
        .cfg_ready  (cfg_ready),
        .prog       (prog),
        .prog_valid (prog_valid),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .busy       (busy)
    );

    always #5 clb_clk = ~clb_clk;

    // Pulse bookkeeping: count done/err pulses and flag overlaps or stretched pulses
    always @(negedge clb_clk) begin
        if (cfg_done) done_cnt++;
        if (cfg_err) err_cnt++;
        if ((cfg_done && cfg_err) || (cfg_done && prev_done) || (cfg_err && prev_err))
            pulse_bad++;
        prev_done = cfg_done;
        prev_err  = cfg_err;
    end

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer one bit until the loader takes it; returns just after the accepting edge
    task automatic send_bit(input logic b, input bit rnd);
        bit   sent;
        logic rdy;
        sent = 0;
        for (int k = 0; k < 200 && !sent; k++) begin
            @(negedge clb_clk);
            cfg_start = 1'b0;
            cfg_bit   = b;
            cfg_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            rdy       = cfg_ready;
            @(posedge clb_clk);
            if (cfg_valid && rdy) begin
                sent = 1;
                acc_cnt++;
            end
        end
        if (!sent) begin
            checks++;
            errors++;
            $error("FAIL send_bit_timeout: observed no accept expected accept");
        end
    endtask

    task automatic send_frame(input logic [PW-1:0] w, input logic p, input bit rnd);
        for (int i = PW - 1; i >= 0; i--) send_bit(w[i], rnd);
        send_bit(p, rnd);
    endtask

    task automatic start_frame();
        @(negedge clb_clk);
        cfg_start = 1'b1;
        cfg_valid = 1'b0;
        @(posedge clb_clk);
    endtask

    initial begin
        clb_rst_n = 1'b0;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
        #12;
        chk("rst_prog", prog, '0);
        chk("rst_prog_valid", prog_valid, 0);
        chk("rst_ready", cfg_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", cfg_done, 0);
        chk("rst_err", cfg_err, 0);
        @(negedge clb_clk);
        clb_rst_n = 1'b1;

        // Bad parity right after reset: error pulse, committed word stays 0/0
        start_frame();
        send_frame(PAT, 1'b0, 0);
        @(negedge clb_clk);
        cfg_valid = 1'b0;
        chk("bad_check_busy", busy, 1);
        @(negedge clb_clk);
        chk("bad_err", cfg_err, 1);
        chk("bad_done", cfg_done, 0);
        chk("bad_prog", prog, '0);
        chk("bad_prog_valid", prog_valid, 0);
        chk("bad_idle", busy, 0);

        // Good frame: nothing visible in CHECK, commit on the edge ending CHECK
        start_frame();
        send_frame(PAT, 1'b1, 0);
        @(negedge clb_clk);
        cfg_valid = 1'b0;
        chk("good_check_prog", prog, '0);
        chk("good_check_done", cfg_done, 0);
        chk("good_check_ready", cfg_ready, 0);
        @(negedge clb_clk);
        chk("good_prog", prog, PAT);
        chk("good_prog_valid", prog_valid, 1);
        chk("good_done", cfg_done, 1);
        chk("good_err", cfg_err, 0);
        @(negedge clb_clk);
        chk("good_done_drop", cfg_done, 0);

        // All-ones frame with random valid gaps
        start_frame();
        acc_cnt = 0;
        send_frame(ONES, 1'b1, 1);
        @(negedge clb_clk);
        cfg_valid = 1'b0;
        chk("ones_check_ready", cfg_ready, 0);
        @(negedge clb_clk);
        chk("ones_prog", prog, ONES);
        chk("ones_done", cfg_done, 1);
        chk("ones_accepts", PW'(acc_cnt), PW'(70));

        // Restart after 30 bits, with a bit offered in the restart cycle
        start_frame();
        for (int i = 0; i < 30; i++) send_bit(i[0], 0);
        @(negedge clb_clk);
        chk("restart_prog_held", prog, ONES);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        @(posedge clb_clk);
        dc = done_cnt;
        ec = err_cnt;
        send_frame(ONE_W, 1'b1, 0);
        @(negedge clb_clk);
        cfg_valid = 1'b0;
        @(negedge clb_clk);
        chk("restart_prog", prog, ONE_W);
        chk("restart_done", cfg_done, 1);
        repeat (3) @(negedge clb_clk);
        chk("restart_done_count", PW'(done_cnt - dc), PW'(1));
        chk("restart_err_count", PW'(err_cnt - ec), PW'(0));

        // Asynchronous reset 50 bits into a frame
        start_frame();
        for (int i = 0; i < 50; i++) send_bit(1'b1, 0);
        @(negedge clb_clk);
        dc = done_cnt;
        clb_rst_n = 1'b0;
        #1;
        chk("midrst_prog", prog, '0);
        chk("midrst_prog_valid", prog_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cfg_ready, 0);
        @(negedge clb_clk);
        clb_rst_n = 1'b1;
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        repeat (5) @(negedge clb_clk);
        chk("midrst_wait_start", busy, 0);
        chk("midrst_no_done", PW'(done_cnt - dc), PW'(0));
        cfg_valid = 1'b0;

        // cfg_start held through CHECK must not restart
        start_frame();
        send_frame(PAT, 1'b1, 0);
        @(negedge clb_clk);
        cfg_valid = 1'b0;
        cfg_start = 1'b1;
        @(negedge clb_clk);
        cfg_start = 1'b0;
        chk("chkstart_done", cfg_done, 1);
        chk("chkstart_prog", prog, PAT);
        chk("chkstart_idle", busy, 0);
        @(negedge clb_clk);
        chk("chkstart_stay_idle", busy, 0);

        @(negedge clb_clk);
        chk("pulse_rules", PW'(pulse_bad), PW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case a wait goes wrong
    initial begin
        #500000;
        $display("FAIL global_timeout: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
